ysyx_23060332_lsu: RTL and testbench
====================================

YSYX_23060332_LSU -- requirements
Module: ysyx_23060332_lsu

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width.
REQ-002 Parameter RD_LAT, default 1, legal 1..4: cycles from mem_ren high to mem_rdata valid.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request from execute stage valid.
REQ-006 in_ready  output  1  LSU accepts request this cycle.
REQ-007 in_load / in_store  input  1 each  request is a load / a store.
REQ-008 in_funct3  input  3  RV32 size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-009 in_addr  input  ADDR_W  byte address.
REQ-010 in_wdata  input  32  store data, right-aligned.
REQ-011 mem_wen  output  1  write strobe to memory stage.
REQ-012 mem_waddr / mem_raddr  output  ADDR_W each  word-aligned write / read address.
REQ-013 mem_wdata  output  32  lane-shifted store data.
REQ-014 mem_wmask  output  8  byte-lane mask; bits [7:4] always 0.
REQ-015 mem_ren  output  1  read strobe.
REQ-016 mem_rdata  input  32  read word from memory stage.
REQ-017 out_valid / out_ready  output / input  1 each  response handshake to writeback.
REQ-018 out_rdata  output  32  extended load result; 0 for stores and errors.
REQ-019 out_err  output  1  misaligned, reserved-funct3, or load+store conflict.

Function
REQ-020 States SHALL be IDLE, STORE, LOAD_WAIT, RESP.
REQ-021 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready; addr, wdata, funct3, load/store are captured on accept.
REQ-022 On accept: valid store -> STORE; valid load -> LOAD_WAIT; neither load nor store -> RESP, out_err=0; error -> RESP, out_err=1, no memory access.
REQ-023 Error: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 in {3,6,7}; store funct3 not in {0,1,2}; in_load & in_store both 1.
REQ-024 STORE: mem_wen=1 for exactly one cycle; mem_waddr = {addr[ADDR_W-1:2],2'b00}; next state RESP.
REQ-025 Store mask[3:0]: B 4'b0001<<addr[1:0]; H 4'b0011<<addr[1:0]; W 4'b1111.
REQ-026 mem_wdata SHALL equal in_wdata << (8*addr[1:0]); unmasked lanes are don't-care.
REQ-027 LOAD_WAIT: mem_ren=1 in the first cycle only; mem_raddr word-aligned; a counter samples mem_rdata in cycle RD_LAT after mem_ren; then RESP.
REQ-028 Load extract: word >> (8*addr[1:0]); B/H sign-extend bit 7/15; BU/HU zero-extend; W unchanged.
REQ-029 RESP: out_valid=1; out_rdata and out_err held stable until out_valid & out_ready; then IDLE.
REQ-030 Latency, accept cycle T: store mem_wen at T+1, out_valid at T+2; load mem_ren at T+1, out_valid at T+2+RD_LAT; no-op/error out_valid at T+1.
REQ-031 mem_wen and mem_ren SHALL never be high in the same cycle, and neither SHALL be high outside STORE / first LOAD_WAIT cycle.
REQ-032 Back-to-back: the next accept occurs no earlier than the cycle after the response handshake; no request overlap.
REQ-033 out_ready held low SHALL stall in RESP indefinitely with no repeat memory access.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, mem_wen=0, mem_ren=0, out_valid=0, out_err=0, out_rdata=0, mem_wmask=0, address/data registers 0, counter 0.
REQ-035 Reset mid-operation discards the in-flight request; late mem_rdata is ignored; in_ready=1 in the first cycle after rst_n rises.

Verification
REQ-036 SB addr 0x8000_0003, wdata 0x0000_00AB -> one cycle mem_wen=1, waddr 0x8000_0000, wmask 0x08, wdata[31:24]=0xAB; out_valid at T+2, out_rdata 0.
REQ-037 LB addr 0x8000_0002, mem_rdata 0x1280_3456, RD_LAT=1 -> mem_ren at T+1, out_rdata 0xFFFF_FF80 at T+3; LBU same -> 0x0000_0080.
REQ-038 LH addr 0x8000_0001 -> no mem_ren/mem_wen, out_err=1, out_valid at T+1.
REQ-039 SW 0x8000_0004, 0xDEAD_BEEF with out_ready low for 5 cycles -> single mem_wen pulse, wmask 0x0F, out_valid held 5 cycles, in_ready=0 throughout.
REQ-040 LW with RD_LAT=3, rst_n pulsed low one cycle after mem_ren -> outputs zero asynchronously, no out_valid, in_ready=1 the cycle after release.

Source files
------------

// File: rtl/ysyx_23060332_lsu_if.sv
// Load/store unit bus: execute-stage request, memory-stage strobes and writeback response.
`timescale 1ns/1ps
interface ysyx_23060332_lsu_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              in_load;
    logic              in_store;
    logic [2:0]        in_funct3;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_wdata;

    logic              mem_wen;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic [7:0]        mem_wmask;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic [31:0]       mem_rdata;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_rdata;
    logic              out_err;

    // Environment side: execute stage, memory stage and writeback together.
    modport master (
        output in_valid, in_load, in_store, in_funct3, in_addr, in_wdata,
        output mem_rdata, out_ready,
        input  in_ready, mem_wen, mem_waddr, mem_wdata, mem_wmask,
        input  mem_ren, mem_raddr, out_valid, out_rdata, out_err
    );

    modport slave (
        input  in_valid, in_load, in_store, in_funct3, in_addr, in_wdata,
        input  mem_rdata, out_ready,
        output in_ready, mem_wen, mem_waddr, mem_wdata, mem_wmask,
        output mem_ren, mem_raddr, out_valid, out_rdata, out_err
    );
endinterface

// File: rtl/ysyx_23060332_lsu.sv
// RV32 load/store unit: one request in flight, lane alignment on stores,
// fixed-latency read sampling and sign/zero extension on loads.
`timescale 1ns/1ps
module ysyx_23060332_lsu #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input logic                clk,
    input logic                rst_n,
    ysyx_23060332_lsu_if.slave bus
);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_STORE     = 2'd1;
    localparam logic [1:0] S_LOAD_WAIT = 2'd2;
    localparam logic [1:0] S_RESP      = 2'd3;
    localparam int unsigned CNT_W = 3;

    logic [1:0]        state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [1:0]        off_q, off_n;
    logic [2:0]        f3_q, f3_n;

    logic              in_ready_q, in_ready_n;
    logic              mem_wen_q, mem_wen_n;
    logic              mem_ren_q, mem_ren_n;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_n;
    logic [ADDR_W-1:0] mem_raddr_q, mem_raddr_n;
    logic [31:0]       mem_wdata_q, mem_wdata_n;
    logic [7:0]        mem_wmask_q, mem_wmask_n;
    logic              out_valid_q, out_valid_n;
    logic [31:0]       out_rdata_q, out_rdata_n;
    logic              out_err_q, out_err_n;

    logic              accept;
    logic              req_err;
    logic [1:0]        req_off;
    logic [ADDR_W-1:0] req_word_addr;
    logic [3:0]        st_mask;
    logic [31:0]       ld_word;
    logic [31:0]       ld_ext;

    // Request decode and load-result extraction.
    always_comb begin
        req_off       = bus.in_addr[1:0];
        req_word_addr = {bus.in_addr[ADDR_W-1:2], 2'b00};
        accept        = bus.in_valid & in_ready_q;

        req_err = 1'b0;
        if (bus.in_load & bus.in_store) begin
            req_err = 1'b1;
        end else if (bus.in_load | bus.in_store) begin
            case (bus.in_funct3)
                3'd0, 3'd4: req_err = bus.in_store & (bus.in_funct3 == 3'd4);
                3'd1, 3'd5: req_err = req_off[0] | (bus.in_store & (bus.in_funct3 == 3'd5));
                3'd2:       req_err = (req_off != 2'd0);
                default:    req_err = 1'b1;
            endcase
        end

        case (bus.in_funct3)
            3'd0:    st_mask = 4'b0001 << req_off;
            3'd1:    st_mask = 4'b0011 << req_off;
            default: st_mask = 4'b1111;
        endcase

        ld_word = bus.mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'd0:    ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
            3'd1:    ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            3'd4:    ld_ext = {24'd0, ld_word[7:0]};
            3'd5:    ld_ext = {16'd0, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
    end

    // Next-state and next-output logic; memory strobes default low every cycle.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        off_n       = off_q;
        f3_n        = f3_q;
        mem_wen_n   = 1'b0;
        mem_ren_n   = 1'b0;
        mem_wmask_n = 8'h00;
        mem_waddr_n = mem_waddr_q;
        mem_raddr_n = mem_raddr_q;
        mem_wdata_n = mem_wdata_q;
        out_valid_n = out_valid_q;
        out_rdata_n = out_rdata_q;
        out_err_n   = out_err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    off_n = req_off;
                    f3_n  = bus.in_funct3;
                    if (req_err || !(bus.in_load || bus.in_store)) begin
                        state_n     = S_RESP;
                        out_valid_n = 1'b1;
                        out_rdata_n = 32'd0;
                        out_err_n   = req_err;
                    end else if (bus.in_store) begin
                        state_n     = S_STORE;
                        mem_wen_n   = 1'b1;
                        mem_waddr_n = req_word_addr;
                        mem_wdata_n = bus.in_wdata << {req_off, 3'b000};
                        mem_wmask_n = {4'b0000, st_mask};
                    end else begin
                        state_n     = S_LOAD_WAIT;
                        mem_ren_n   = 1'b1;
                        mem_raddr_n = req_word_addr;
                        cnt_n       = '0;
                    end
                end
            end
            S_STORE: begin
                state_n     = S_RESP;
                out_valid_n = 1'b1;
                out_rdata_n = 32'd0;
                out_err_n   = 1'b0;
            end
            S_LOAD_WAIT: begin
                // cnt counts cycles since the read strobe; data is valid at RD_LAT.
                if (cnt_q == CNT_W'(RD_LAT)) begin
                    state_n     = S_RESP;
                    out_valid_n = 1'b1;
                    out_rdata_n = ld_ext;
                    out_err_n   = 1'b0;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.out_ready) begin
                    state_n     = S_IDLE;
                    out_valid_n = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        in_ready_n = (state_n == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            off_q       <= 2'd0;
            f3_q        <= 3'd0;
            in_ready_q  <= 1'b1;
            mem_wen_q   <= 1'b0;
            mem_ren_q   <= 1'b0;
            mem_waddr_q <= '0;
            mem_raddr_q <= '0;
            mem_wdata_q <= 32'd0;
            mem_wmask_q <= 8'h00;
            out_valid_q <= 1'b0;
            out_rdata_q <= 32'd0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            off_q       <= off_n;
            f3_q        <= f3_n;
            in_ready_q  <= in_ready_n;
            mem_wen_q   <= mem_wen_n;
            mem_ren_q   <= mem_ren_n;
            mem_waddr_q <= mem_waddr_n;
            mem_raddr_q <= mem_raddr_n;
            mem_wdata_q <= mem_wdata_n;
            mem_wmask_q <= mem_wmask_n;
            out_valid_q <= out_valid_n;
            out_rdata_q <= out_rdata_n;
            out_err_q   <= out_err_n;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_wen   = mem_wen_q;
    assign bus.mem_ren   = mem_ren_q;
    assign bus.mem_waddr = mem_waddr_q;
    assign bus.mem_raddr = mem_raddr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wmask = mem_wmask_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_rdata = out_rdata_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Scoreboard bench for the LSU: byte-level reference model, fixed-latency memory
// responder, random back-pressure, and a negedge monitor that checks every strobe and response.
`timescale 1ns/1ps
module tb_ysyx_23060332_lsu;
    localparam int unsigned AW     = 32;
    localparam int unsigned RD_LAT = 3;

    logic clk = 1'b0;
    logic rst_n;

    ysyx_23060332_lsu_if #(.ADDR_W(AW)) bus ();

    ysyx_23060332_lsu #(.ADDR_W(AW), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [31:0] data;
        logic [31:0] dmask;
        int          cyc;
    } mem_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          first;
        int          stall;
    } resp_exp_t;

    mem_exp_t  memq[$];
    resp_exp_t respq[$];
    mem_exp_t  mon_m;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit busy = 1'b0;
    bit seen_first = 1'b0;
    int stalls = 0;
    int stall_n = 0;
    bit ready_rand = 1'b0;
    int vcnt = 0;
    int rd_cd = -1;
    logic [31:0] rd_word = 32'd0;

    always @(posedge clk) cyc++;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void flag(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endfunction

    function automatic void check_zero(input string tag);
        chk({tag, "_mem_wen"},   32'(bus.mem_wen),   32'd0);
        chk({tag, "_mem_ren"},   32'(bus.mem_ren),   32'd0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_err"},   32'(bus.out_err),   32'd0);
        chk({tag, "_out_rdata"}, bus.out_rdata,      32'd0);
        chk({tag, "_mem_wmask"}, 32'(bus.mem_wmask), 32'd0);
        chk({tag, "_mem_waddr"}, bus.mem_waddr,      32'd0);
        chk({tag, "_mem_raddr"}, bus.mem_raddr,      32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
    endfunction

    // Memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h1280_3456;
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    function automatic int size_bytes(input int f3);
        case (f3 % 4)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit model_err(input bit ld, input bit st, input int f3, input logic [31:0] addr);
        if (ld && st) return 1'b1;
        if (!ld && !st) return 1'b0;
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        if (st && f3 > 2) return 1'b1;
        return (addr % size_bytes(f3)) != 0;
    endfunction

    // Expected memory access and response for a request accepted in cycle t.
    function automatic void expect_op(input bit ld, input bit st, input int f3,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      input int t, input int stall);
        resp_exp_t r;
        mem_exp_t  m;
        int off;
        int nb;
        logic [31:0] word;
        logic [31:0] res;
        off = int'(addr % 4);
        nb  = size_bytes(f3);
        r.rdata = 32'd0;
        r.err   = model_err(ld, st, f3, addr);
        r.stall = stall;
        m.wr = 1'b0; m.addr = addr & 32'hFFFF_FFFC; m.mask = 8'h00;
        m.data = 32'd0; m.dmask = 32'd0; m.cyc = t + 1;
        if (r.err || (!ld && !st)) begin
            r.first = t + 1;
        end else if (st) begin
            m.wr = 1'b1;
            for (int i = 0; i < nb; i++) begin
                m.mask[off + i]          = 1'b1;
                m.data[8*(off+i) +: 8]   = wdata[8*i +: 8];
                m.dmask[8*(off+i) +: 8]  = 8'hFF;
            end
            memq.push_back(m);
            r.first = t + 2;
        end else begin
            word = mem_word(m.addr);
            res  = 32'd0;
            for (int i = 0; i < nb; i++) res[8*i +: 8] = word[8*(off+i) +: 8];
            if (f3 < 4 && nb < 4 && res[8*nb-1])
                for (int i = nb; i < 4; i++) res[8*i +: 8] = 8'hFF;
            r.rdata = res;
            memq.push_back(m);
            r.first = t + 2 + int'(RD_LAT);
        end
        respq.push_back(r);
    endfunction

    // Fixed-latency memory: valid word only in the cycle RD_LAT after the read strobe.
    always @(posedge clk) begin
        #1;
        if (rd_cd >= 0) rd_cd--;
        if (bus.mem_ren === 1'b1) begin
            rd_cd   = int'(RD_LAT);
            rd_word = mem_word(bus.mem_raddr);
        end
        bus.mem_rdata = (rd_cd == 0) ? rd_word : $urandom;
    end

    // Writeback back-pressure: forced stall for the first stall_n response cycles, else random or ready.
    always @(posedge clk) begin
        #1;
        if (bus.out_valid !== 1'b1) vcnt = 0;
        else vcnt++;
        if (vcnt > 0 && vcnt <= stall_n) bus.out_ready = 1'b0;
        else if (ready_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
        else bus.out_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 1'b0;
            seen_first = 1'b0;
            stalls = 0;
            check_zero("rst");
        end else begin
            chk("in_ready", 32'(bus.in_ready), busy ? 32'd0 : 32'd1);
            if (bus.in_valid && bus.in_ready) busy = 1'b1;
            if (bus.mem_wen && bus.mem_ren) flag("wen_ren_overlap");
            if (bus.mem_wen || bus.mem_ren) begin
                if (memq.size() == 0) begin
                    flag("unexpected_mem_access");
                end else begin
                    mon_m = memq.pop_front();
                    chk("mem_kind_is_write", 32'(bus.mem_wen), 32'(mon_m.wr));
                    chk("mem_cycle", 32'(cyc), 32'(mon_m.cyc));
                    if (mon_m.wr) begin
                        chk("mem_waddr", bus.mem_waddr, mon_m.addr);
                        chk("mem_wmask", 32'(bus.mem_wmask), 32'(mon_m.mask));
                        chk("mem_wdata_lanes", bus.mem_wdata & mon_m.dmask, mon_m.data);
                    end else begin
                        chk("mem_raddr", bus.mem_raddr, mon_m.addr);
                    end
                end
            end
            if (bus.out_valid) begin
                if (respq.size() == 0) begin
                    flag("unexpected_out_valid");
                end else begin
                    if (!seen_first) begin
                        chk("resp_cycle", 32'(cyc), 32'(respq[0].first));
                        seen_first = 1'b1;
                        stalls = 0;
                    end
                    chk("out_rdata", bus.out_rdata, respq[0].rdata);
                    chk("out_err", 32'(bus.out_err), 32'(respq[0].err));
                    if (bus.out_ready) begin
                        if (respq[0].stall >= 0) chk("stall_cycles", 32'(stalls), 32'(respq[0].stall));
                        void'(respq.pop_front());
                        busy = 1'b0;
                        seen_first = 1'b0;
                    end else begin
                        stalls++;
                    end
                end
            end
        end
    end

    // Present one request (called just after a rising edge) and record its expectations on accept.
    task automatic issue(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input int stall);
        bit acc = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_load   = ld;
        bus.in_store  = st;
        bus.in_funct3 = f3;
        bus.in_addr   = addr;
        bus.in_wdata  = wdata;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (acc) expect_op(ld, st, int'(f3), addr, wdata, cyc, stall);
        else flag("accept_timeout");
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_load   = 1'($urandom);
        bus.in_store  = 1'($urandom);
        bus.in_funct3 = 3'($urandom);
        bus.in_addr   = $urandom;
        bus.in_wdata  = $urandom;
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (!busy && respq.size() == 0 && memq.size() == 0) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) flag("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ld, st;
        int r;
        logic [2:0]  f3;
        logic [31:0] addr;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_load = 1'b0; bus.in_store = 1'b0;
        bus.in_funct3 = 3'd0; bus.in_addr = 32'd0; bus.in_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases: SB to lane 3, LB/LBU sign handling, misaligned LH.
        issue(1'b0, 1'b1, 3'd0, 32'h8000_0003, 32'h0000_00AB, -1);
        issue(1'b1, 1'b0, 3'd0, 32'h8000_0002, $urandom, -1);
        issue(1'b1, 1'b0, 3'd4, 32'h8000_0002, $urandom, -1);
        issue(1'b1, 1'b0, 3'd1, 32'h8000_0001, $urandom, -1);
        issue(1'b1, 1'b1, 3'd2, 32'h8000_0008, $urandom, -1);
        issue(1'b0, 1'b0, 3'd0, 32'h8000_000C, $urandom, -1);
        wait_idle();

        // SW held off by five cycles of out_ready low.
        stall_n = 5;
        issue(1'b0, 1'b1, 3'd2, 32'h8000_0004, 32'hDEAD_BEEF, 5);
        wait_idle();
        stall_n = 0;

        // LW aborted by reset one cycle after its read strobe.
        issue(1'b1, 1'b0, 3'd2, 32'h8000_0010, $urandom, -1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        memq.delete();
        respq.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
        repeat (8) @(posedge clk);
        #1;

        // Random traffic with random back-pressure.
        ready_rand = 1'b1;
        for (int n = 0; n < 250; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            r = int'($urandom_range(0, 99));
            ld = (r < 45) || (r >= 85 && r < 90);
            st = (r >= 45 && r < 90);
            f3 = (r >= 90) ? 3'd0 : 3'($urandom_range(0, 7));
            addr = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
            if ($urandom_range(0, 1) == 1) begin
                if (f3 == 3'd2) addr = addr & 32'hFFFF_FFFC;
                else if (f3 == 3'd1 || f3 == 3'd5) addr = addr & 32'hFFFF_FFFE;
            end
            issue(ld, st, f3, addr, $urandom, -1);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
